// File: rtl/spi_periph_regs.sv
// spi_periph_regs: SPI mode-0 responder turning oversampled frames into register bus strobes.
// Define SPI_PERIPH_BURST_EN for auto-incrementing multi-byte bursts.
module spi_periph_regs #(
  parameter int C_ADR_W = 7,
  parameter int C_DAT_W = 8
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               SCLK_i,
  input  logic               XSS_i,
  input  logic               COPI_i,
  output logic               CIPO_o,
  output logic               CIPO_OE_o,
  output logic [C_ADR_W-1:0] ADRs_o,
  output logic [C_DAT_W-1:0] WDATs_o,
  output logic               WR_o,
  output logic               RD_REQ_o,
  input  logic [C_DAT_W-1:0] RDATs_i,
  output logic               BUSY_o
);
`ifdef SPI_PERIPH_BURST_EN
  localparam bit burst = 1'b1;
`else
  localparam bit burst = 1'b0;
`endif
  localparam logic [1:0] st_idle = 2'd0, st_cmd = 2'd1, st_data = 2'd2;
  logic [2:0] sclk_q, xss_q, copi_q;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [C_DAT_W-1:0] sh, tx, rx_byte;
  logic rw, first, skip, ld, armed;
  logic sclk_rise, sclk_fall, xss_rise, xss_fall, act;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign xss_rise  = xss_q[1] & ~xss_q[2];
  assign xss_fall  = ~xss_q[1] & xss_q[2];
  // COPI is taken from the history stage: the value just before SCLK rose
  assign rx_byte   = {sh[C_DAT_W-2:0], copi_q[2]};
  assign act       = burst | first;
  // XSS sync resets to asserted, so a frame already running at reset release never starts
  assign BUSY_o    = armed & ~xss_q[1];
  assign CIPO_OE_o = BUSY_o;
  assign CIPO_o    = tx[C_DAT_W-1] & rw & act & (state == st_data);
  always_ff @(posedge CK_i or negedge XARST_i)
    if (!XARST_i) begin
      sclk_q <= '0;
      xss_q  <= '0;
      copi_q <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK_i};
      xss_q  <= {xss_q[1:0], XSS_i};
      copi_q <= {copi_q[1:0], COPI_i};
      armed  <= armed | xss_q[1];
    end
  always_ff @(posedge CK_i or negedge XARST_i)
    if (!XARST_i) begin
      state    <= st_idle;
      cnt      <= '0;
      sh       <= '0;
      tx       <= '0;
      rw       <= 1'b0;
      first    <= 1'b0;
      skip     <= 1'b0;
      ld       <= 1'b0;
      ADRs_o   <= '0;
      WDATs_o  <= '0;
      WR_o     <= 1'b0;
      RD_REQ_o <= 1'b0;
    end else begin
      WR_o     <= 1'b0;
      RD_REQ_o <= 1'b0;
      ld       <= RD_REQ_o;
      if (burst && WR_o) ADRs_o <= ADRs_o + C_ADR_W'(1);
      if (ld) tx <= RDATs_i;
      else if (sclk_fall && state != st_idle) begin
        skip <= 1'b0;
        if (!skip) tx <= {tx[C_DAT_W-2:0], 1'b0};
      end
      if (xss_rise) state <= st_idle;
      else if (state == st_idle) begin
        if (xss_fall) begin
          state <= st_cmd;
          cnt   <= '0;
          skip  <= 1'b0;
          first <= 1'b1;
        end
      end else if (sclk_rise) begin
        sh  <= rx_byte;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          skip <= 1'b1;
          if (state == st_cmd) begin
            ADRs_o   <= rx_byte[C_ADR_W-1:0];
            rw       <= rx_byte[C_DAT_W-1];
            RD_REQ_o <= rx_byte[C_DAT_W-1];
            state    <= st_data;
          end else begin
            first <= 1'b0;
            if (act) begin
              if (rw) begin
                RD_REQ_o <= burst;
                if (burst) ADRs_o <= ADRs_o + C_ADR_W'(1);
              end else begin
                WR_o    <= 1'b1;
                WDATs_o <= rx_byte;
              end
            end
          end
        end
      end
    end
endmodule

// File: tb/tb_spi_periph_regs.sv
// tb_spi_periph_regs: directed SPI frames against a responder memory and a register model.
module tb_spi_periph_regs;
`ifdef SPI_PERIPH_BURST_EN
  localparam bit burst = 1'b1;
`else
  localparam bit burst = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, xss = 1'b1, copi = 1'b0;
  logic cipo, cipo_oe, wr, rd_req, busy;
  logic [6:0] adr;
  logic [7:0] wdat, rdat = 8'h00;
  logic [7:0] mem [128];
  int wr_n = 0, rd_n = 0, both_n = 0;
  logic [6:0] wr_adr = '0, rd_adr = '0;
  logic [7:0] wr_dat = '0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  spi_periph_regs dut (
    .CK_i(clk), .XARST_i(rst_n), .SCLK_i(sclk), .XSS_i(xss), .COPI_i(copi),
    .CIPO_o(cipo), .CIPO_OE_o(cipo_oe), .ADRs_o(adr), .WDATs_o(wdat),
    .WR_o(wr), .RD_REQ_o(rd_req), .RDATs_i(rdat), .BUSY_o(busy)
  );
  // responder register file: takes writes, answers read requests
  always @(negedge clk) begin
    if (wr) begin
      wr_n++;
      wr_adr = adr;
      wr_dat = wdat;
      mem[adr] = wdat;
    end
    if (rd_req) begin
      rd_n++;
      rd_adr = adr;
      rdat = mem[adr];
    end
    if (wr && rd_req) both_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ck(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      copi = b[i];
      ck(4);
      r[i] = cipo;
      sclk = 1'b1;
      ck(4);
    end
  endtask
  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      copi = 1'b0;
      ck(4);
      sclk = 1'b1;
      ck(4);
    end
  endtask
  task automatic xss_lo;
    xss = 1'b0;
    ck(4);
  endtask
  task automatic xss_hi;
    sclk = 1'b0;
    ck(4);
    xss = 1'b1;
    ck(8);
  endtask
  initial begin
    logic [7:0] r0, r1, r2;
    logic [7:0] model [8];
    bit valid [8];
    logic [6:0] a;
    logic [7:0] d;
    bit rd;
    int w0, q0;
    for (int i = 0; i < 8; i++) valid[i] = 1'b0;
    ck(3);
    chk("rst_cipo", cipo, 0);
    chk("rst_oe", cipo_oe, 0);
    chk("rst_adr", adr, 0);
    chk("rst_wdat", wdat, 0);
    chk("rst_strobes", {wr, rd_req}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    ck(8);
    chk("idle_busy", busy, 0);
    // single write
    w0 = wr_n; q0 = rd_n;
    xss_lo;
    chk("busy_in_frame", {busy, cipo_oe}, 2'b11);
    spi_byte(8'h05, r0);
    spi_byte(8'hA5, r1);
    xss_hi;
    chk("wr_count", wr_n - w0, 1);
    chk("wr_no_rd", rd_n - q0, 0);
    chk("wr_adr", wr_adr, 7'h05);
    chk("wr_dat", wr_dat, 8'hA5);
    chk("wr_adr_after", adr, burst ? 7'h06 : 7'h05);
    chk("wr_wdat_hold", wdat, 8'hA5);
    chk("wr_cipo_zero", {r0, r1}, 16'h0000);
    chk("busy_after", busy, 0);
    // preload values for the read and reset tests
    xss_lo; spi_byte(8'h03, r0); spi_byte(8'h3C, r1); xss_hi;
    xss_lo; spi_byte(8'h06, r0); spi_byte(8'hFF, r1); xss_hi;
    // single read
    w0 = wr_n; q0 = rd_n;
    xss_lo;
    spi_byte(8'h83, r0);
    spi_byte(8'h00, r1);
    xss_hi;
    chk("rd_cmd_cipo", r0, 8'h00);
    chk("rd_data", r1, 8'h3C);
    chk("rd_count", rd_n - q0, burst ? 2 : 1);
    chk("rd_adr", rd_adr, burst ? 7'h04 : 7'h03);
    chk("rd_no_wr", wr_n - w0, 0);
    // three-byte write starting at the top address
    mem[0] = 8'h99;
    w0 = wr_n;
    xss_lo;
    spi_byte(8'h7F, r0);
    spi_byte(8'h11, r1);
    spi_byte(8'h22, r2);
    xss_hi;
    chk("bw_count", wr_n - w0, burst ? 2 : 1);
    chk("bw_mem7f", mem[127], 8'h11);
    chk("bw_mem00", mem[0], burst ? 8'h22 : 8'h99);
    chk("bw_last_adr", wr_adr, burst ? 7'h00 : 7'h7F);
    chk("bw_cipo_zero", {r1, r2}, 16'h0000);
    // abort halfway through a data byte
    w0 = wr_n; q0 = rd_n;
    xss_lo;
    spi_byte(8'h09, r0);
    spi_bits(4);
    xss_hi;
    chk("abort_no_wr", wr_n - w0, 0);
    chk("abort_no_rd", rd_n - q0, 0);
    w0 = wr_n;
    xss_lo; spi_byte(8'h01, r0); spi_byte(8'h55, r1); xss_hi;
    chk("post_abort_wr", wr_n - w0, 1);
    chk("post_abort_adr", wr_adr, 7'h01);
    chk("post_abort_dat", wr_dat, 8'h55);
    // async reset in the middle of a read of 0xFF
    xss_lo;
    spi_byte(8'h86, r0);
    spi_bits(4);
    chk("pre_rst_cipo", {cipo, cipo_oe, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cipo", {cipo, cipo_oe}, 2'b00);
    chk("mid_rst_adr", adr, 0);
    chk("mid_rst_wdat", wdat, 0);
    chk("mid_rst_busy", {busy, wr, rd_req}, 3'b000);
    ck(2);
    rst_n = 1'b1;
    w0 = wr_n; q0 = rd_n;
    ck(4);
    spi_bits(4);
    xss_hi;
    chk("post_rst_strobes", (wr_n - w0) + (rd_n - q0), 0);
    chk("post_rst_adr", adr, 0);
    w0 = wr_n;
    xss_lo; spi_byte(8'h02, r0); spi_byte(8'h6B, r1); xss_hi;
    chk("post_rst_wr", {wr_adr, wr_dat}, {7'h02, 8'h6B});
    chk("post_rst_wr_count", wr_n - w0, 1);
    // random frames on a small address window against the model
    for (int i = 0; i < 24; i++) begin
      a = 7'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      rd = valid[a[2:0]] && ($urandom_range(0, 1) == 1);
      xss_lo;
      spi_byte({rd, a}, r0);
      spi_byte(d, r1);
      xss_hi;
      if (rd) chk("rnd_rd", r1, model[a[2:0]]);
      else begin
        model[a[2:0]] = d;
        valid[a[2:0]] = 1'b1;
        chk("rnd_wr", {wr_adr, wr_dat}, {a, d});
      end
    end
    chk("wr_rd_overlap", both_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
